// File: rtl/ucode_pkg.sv
// ucode_pkg: sequencer opcodes, controller states and microword control-field offsets.
package ucode_pkg;
  typedef enum logic [2:0] {OP_CONT, OP_JUMP, OP_JCOND, OP_CALL, OP_CCALL, OP_RET, OP_MAP, OP_CASE} seq_op_e;
  typedef enum logic {ST_RST, ST_RUN} state_e;
  // Offsets are relative to bit AW, just above the target field.
  localparam int COND_SEL_OFS = 0;
  localparam int COND_SEL_W = 4;
  localparam int COND_POL_OFS = 4;
  localparam int SEQ_OP_OFS = 5;
  localparam int SEQ_OP_W = 3;
  localparam int CTRL_W = 8;
endpackage

// File: rtl/ucode_controller_if.sv
// ucode_controller_if: code ROM, dispatch, condition and status signals of the sequencer.
interface ucode_controller_if #(parameter int AW = 11, parameter int UW = 56, parameter int NCOND = 8) ();
  logic [AW-1:0] uc_addr;
  logic [UW-1:0] uc_data;
  logic [UW-1:0] pipeline;
  logic [AW-1:0] map_data;
  logic [NCOND-1:0] cond;
  logic [3:0] case_bits;
  logic wait_n;
  logic irq;
  logic irq_ack;
  logic instruction_start;
  logic stack_err;
  modport master (
    output uc_addr, pipeline, irq_ack, instruction_start, stack_err,
    input uc_data, map_data, cond, case_bits, wait_n, irq
  );
  modport slave (
    input uc_addr, pipeline, irq_ack, instruction_start, stack_err,
    output uc_data, map_data, cond, case_bits, wait_n, irq
  );
endinterface

// File: rtl/ucode_stack.sv
// ucode_stack: return-address LIFO; pushes when full and pops when empty are ignored.
module ucode_stack #(
  parameter int DEPTH = 4,
  parameter int AW = 11
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] top,
  output logic full,
  output logic empty
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] mem [1 << CW];
  logic [CW-1:0] cnt, tidx;
  assign tidx = cnt - 1'b1;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign top = mem[tidx];
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else if (push && !full) cnt <= cnt + 1'b1;
    else if (pop && !empty) cnt <= cnt - 1'b1;
  always_ff @(posedge clock)
    if (push && !full) mem[cnt] <= din;
endmodule

// File: rtl/ucode_controller.sv
// ucode_controller: microprogram sequencer with call stack, map and case dispatch.
// Define UCODE_CONTROLLER_IRQ_EN to divert MAP dispatches to IRQ_VEC while irq is high.
module ucode_controller
  import ucode_pkg::*;
#(
  parameter int AW = 11,
  parameter int UW = 56,
  parameter int DEPTH = 4,
  parameter int NCOND = 8,
  parameter int RESET_VEC = 0,
  parameter int FETCH_VEC = 'h101,
  parameter int IRQ_VEC = 'h7F0
) (
  input logic clock,
  input logic reset,
  ucode_controller_if.master bus
);
  localparam int CSW = $clog2(NCOND);
  state_e state;
  seq_op_e op;
  logic [UW-1:0] pipe;
  logic [AW-1:0] upc, inc, nxt, addr, target, push_data, top;
  logic [CSW-1:0] sel;
  logic hit, push_req, pop_req, take_irq, adv, full, empty;
  logic stack_err, irq_ack, istart;
  assign target = pipe[AW-1:0];
  assign sel = pipe[AW+COND_SEL_OFS +: CSW];
  assign op = seq_op_e'(pipe[AW+SEQ_OP_OFS +: SEQ_OP_W]);
  assign hit = bus.cond[sel] ^ pipe[AW+COND_POL_OFS];
  assign inc = upc + 1'b1;
  assign adv = state == ST_RUN && bus.wait_n;
  always_comb begin
    nxt = inc;
    push_req = 1'b0;
    pop_req = 1'b0;
    take_irq = 1'b0;
    push_data = inc;
    case (op)
      OP_JUMP: nxt = target;
      OP_JCOND: nxt = hit ? target : inc;
      OP_CALL: begin
        nxt = target;
        push_req = 1'b1;
      end
      OP_CCALL: begin
        nxt = hit ? target : inc;
        push_req = hit;
      end
      OP_RET: begin
        nxt = empty ? inc : top;
        pop_req = 1'b1;
      end
`ifdef UCODE_CONTROLLER_IRQ_EN
      OP_MAP: begin
        nxt = bus.irq ? AW'(IRQ_VEC) : bus.map_data;
        push_req = bus.irq;
        take_irq = bus.irq;
        push_data = bus.map_data;
      end
`else
      OP_MAP: nxt = bus.map_data;
`endif
      OP_CASE: nxt = {target[AW-1:4], target[3:0] | bus.case_bits};
      default: ;
    endcase
  end
`ifndef UCODE_CONTROLLER_IRQ_EN
  logic unused_irq;
  assign unused_irq = bus.irq;
`endif
  // A stalled cycle re-presents upc so the ROM output stays on the current word.
  assign addr = state == ST_RST ? AW'(RESET_VEC) : !bus.wait_n ? upc : nxt;
  ucode_stack #(.DEPTH(DEPTH), .AW(AW)) u_stack (
    .clock(clock),
    .reset(reset),
    .push(adv && push_req),
    .pop(adv && pop_req),
    .din(push_data),
    .top(top),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= ST_RST;
      pipe <= '0;
      upc <= AW'(RESET_VEC);
      stack_err <= 1'b0;
      irq_ack <= 1'b0;
      istart <= 1'b0;
    end else begin
      irq_ack <= adv && take_irq;
      if (state == ST_RST || bus.wait_n) begin
        state <= ST_RUN;
        pipe <= bus.uc_data;
        upc <= addr;
        istart <= addr == AW'(FETCH_VEC);
      end
      if (adv && ((push_req && full) || (pop_req && empty))) stack_err <= 1'b1;
    end
  assign bus.uc_addr = addr;
  assign bus.pipeline = pipe;
  assign bus.stack_err = stack_err;
  assign bus.irq_ack = irq_ack;
  assign bus.instruction_start = istart;
endmodule

// File: doc/ucode_controller.md
UCODE_CONTROLLER -- requirements
Module: ucode_controller

Interface
REQ-001 Parameter AW, default 11: microcode address width.
REQ-002 Parameter UW, default 56: microword width; UW SHALL be at least AW+8.
REQ-003 Parameter DEPTH, default 4: subroutine stack depth, 1..16.
REQ-004 Parameter NCOND, default 8: condition input count, power of two, 2..16.
REQ-005 Parameter RESET_VEC, default 0: first microaddress after reset.
REQ-006 Parameter FETCH_VEC, default 'h101: instruction-fetch microaddress.
REQ-007 Parameter IRQ_VEC, default 'h7F0: interrupt microroutine address.
REQ-008 Port clock, in, 1: single clock; all state changes on the rising edge.
REQ-009 Port reset, in, 1: asynchronous, active-low reset.
REQ-010 Port uc_addr, out, AW: combinational next microaddress to the code ROM.
REQ-011 Port uc_data, in, UW: code ROM data for uc_addr.
REQ-012 Port pipeline, out, UW: registered current microword.
REQ-013 Port map_data, in, AW: map ROM dispatch address.
REQ-014 Port cond, in, NCOND: branch conditions.
REQ-015 Port case_bits, in, 4: bits ORed into the target for CASE.
REQ-016 Port wait_n, in, 1: low stalls the controller (bus wait state).
REQ-017 Port irq, in, 1: interrupt request, level-sensitive.
REQ-018 Port irq_ack, out, 1: one-cycle interrupt-taken pulse.
REQ-019 Port instruction_start, out, 1: high while upc equals FETCH_VEC in RUN.
REQ-020 Port stack_err, out, 1: sticky stack overflow/underflow flag.

Function
REQ-021 Microword fields SHALL be target=[AW-1:0], cond_sel=[AW+3:AW], cond_pol=[AW+4], seq_op=[AW+7:AW+5]; all remaining bits pass through to pipeline unchanged.
REQ-022 States SHALL be RST and RUN; RST drives uc_addr=RESET_VEC and moves to RUN on the first edge after reset deasserts.
REQ-023 On each advancing edge (RUN, wait_n=1), pipeline SHALL load uc_data and upc SHALL load uc_addr.
REQ-024 seq_op CONT(0): uc_addr=upc+1, wrapping modulo 2^AW.
REQ-025 JUMP(1): uc_addr=target.
REQ-026 JCOND(2): uc_addr=target if cond[cond_sel]^cond_pol is 1, else upc+1.
REQ-027 CALL(3): push upc+1 and jump to target; CCALL(4): the same only if the JCOND condition is true, else upc+1.
REQ-028 RET(5): uc_addr=top of stack, with the pop on the advancing edge.
REQ-029 MAP(6): uc_addr=map_data.
REQ-030 CASE(7): uc_addr={target[AW-1:4], target[3:0]|case_bits}.
REQ-031 While wait_n=0, the controller SHALL drive uc_addr=upc, hold pipeline and stack, and leave the latency to the next microword at exactly one cycle after wait_n returns to 1.
REQ-032 A push with a full stack SHALL discard the push, still jump, and set stack_err.
REQ-033 A pop with an empty stack SHALL return upc+1 and set stack_err.
REQ-034 A push and a pop never coincide; the stack SHALL be modified only on advancing edges.

Reset
REQ-035 Reset SHALL force the state to RST, pipeline=0, upc=RESET_VEC, stack empty, stack_err=0, irq_ack=0, and instruction_start=0.
REQ-036 Reset asserted mid-stall or mid-subroutine SHALL discard all state immediately.

Configuration
REQ-037 With macro UCODE_CONTROLLER_IRQ_EN defined, a MAP with irq=1 SHALL drive uc_addr=IRQ_VEC, push map_data, and pulse irq_ack on that advancing edge; the push follows the overflow rule.
REQ-038 Without UCODE_CONTROLLER_IRQ_EN, irq SHALL be ignored and irq_ack tied to 0.

Structure
REQ-039 A shared package ucode_pkg SHALL hold the seq_op enumeration, the field-offset constants, and the state enumeration.
REQ-040 The stack SHALL be a sub-module ucode_stack (DEPTH, AW; push, pop, top, full, empty).

Verification
REQ-041 Reset release, ROM[0]=JUMP 'h101 -> uc_addr 0, then 'h101, and instruction_start high the next cycle.
REQ-042 JCOND sel=3, pol=0, cond[3]=1 -> target; cond[3]=0 -> upc+1; pol=1 inverts both outcomes.
REQ-043 Five nested CALLs with DEPTH=4 -> stack_err=1 after the fifth; four RETs return correctly; the fifth RET yields upc+1.
REQ-044 CASE target 'h230, case_bits=5 -> uc_addr 'h235; upc='h7FF with CONT -> 0.
REQ-045 wait_n low for 3 cycles during CALL -> exactly one push, pipeline held, and the target fetched one cycle after release.
REQ-046 IRQ_EN build, MAP map_data='h4A, irq=1 -> uc_addr 'h7F0, irq_ack pulse, and a later RET gives 'h4A; non-IRQ build -> 'h4A directly.
